// File: rtl/deser_align_ctrl_if.sv
// Bundles the alignment controller's start/data/status signals.
// Latency: none (wires only).
// Backpressure: none; i_start is a one-cycle request, status outputs are levels.
// master: sensor interface top (drives i_start, iv_data; reads status).
// slave : deser_align_ctrl (reads i_start, iv_data; drives bitslip/lock/status).
interface deser_align_ctrl_if #(
  parameter int CHANNEL_NUM = 4,
  parameter int DESER_WIDTH = 6
);
  logic                               i_start;
  logic [CHANNEL_NUM*DESER_WIDTH-1:0] iv_data;
  logic [CHANNEL_NUM-1:0]             ov_bitslip;
  logic [CHANNEL_NUM-1:0]             ov_chn_lock;
  logic                               o_align_busy;
  logic                               o_align_done;
  logic                               o_align_fail;

  modport master (
    output i_start, iv_data,
    input  ov_bitslip, ov_chn_lock, o_align_busy, o_align_done, o_align_fail
  );

  modport slave (
    input  i_start, iv_data,
    output ov_bitslip, ov_chn_lock, o_align_busy, o_align_done, o_align_fail
  );
endinterface

// File: rtl/deser_align_ctrl.sv
// Word-alignment sequencer: walks each ISERDES channel, pulsing BITSLIP until the
// parallel word equals the training word for MATCH_NUM consecutive cycles.
// Latency: all outputs registered; busy rises the cycle after i_start is sampled.
// Backpressure: none; i_start is ignored while a sequence is in progress.
// Ports: clk (recovered parallel clock), reset_n (sync, active low),
//   bus.slave: i_start, iv_data in; ov_bitslip, ov_chn_lock, o_align_busy,
//   o_align_done, o_align_fail out.
module deser_align_ctrl #(
  parameter int                     CHANNEL_NUM   = 4,
  parameter int                     DESER_WIDTH   = 6,
  parameter logic [DESER_WIDTH-1:0] TRAINING_WORD = 'h38,
  parameter int                     SLIP_WAIT     = 4,
  parameter int                     MATCH_NUM     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  deser_align_ctrl_if.slave    bus
);

  localparam int CH_W    = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int SLIP_W  = $clog2(DESER_WIDTH + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int MATCH_W = $clog2(MATCH_NUM + 1);

  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(CHANNEL_NUM - 1);
  localparam logic [SLIP_W-1:0]  SLIP_LAST  = SLIP_W'(DESER_WIDTH - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_SLIP,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [CH_W-1:0]        ch_idx, ch_nxt;
  logic [SLIP_W-1:0]      slip_cnt, slip_nxt;
  logic [WAIT_W-1:0]      wait_cnt, wait_nxt;
  logic [MATCH_W-1:0]     match_cnt, match_nxt;
  logic                   fail_flag, fail_nxt;
  logic [CHANNEL_NUM-1:0] chn_lock, lock_nxt;
  logic [CHANNEL_NUM-1:0] bitslip, bitslip_nxt;
  logic                   busy, busy_nxt;
  logic                   done, done_nxt;
  logic                   fail_out, fail_out_nxt;

  logic [DESER_WIDTH-1:0] sel_word;
  logic [CHANNEL_NUM-1:0] ch_onehot;

  // Channel mux and one-hot decode of the selected channel; only this word is examined.
  always_comb begin
    sel_word  = '0;
    ch_onehot = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (ch_idx == CH_W'(i)) begin
        sel_word     = bus.iv_data[i*DESER_WIDTH +: DESER_WIDTH];
        ch_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch_idx;
    slip_nxt    = slip_cnt;
    wait_nxt    = wait_cnt;
    match_nxt   = match_cnt;
    fail_nxt    = fail_flag;
    lock_nxt    = chn_lock;
    bitslip_nxt = '0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          state_nxt = ST_WAIT;
          ch_nxt    = '0;
          slip_nxt  = '0;
          wait_nxt  = '0;
          match_nxt = '0;
          fail_nxt  = 1'b0;
          lock_nxt  = '0;
        end
      end
      ST_WAIT: begin
        // Settle window after channel select or bitslip: exactly SLIP_WAIT cycles.
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_CHECK;
          match_nxt = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_CHECK: begin
        if (sel_word == TRAINING_WORD) begin
          if (match_cnt == MATCH_LAST) begin
            lock_nxt  = chn_lock | ch_onehot;
            state_nxt = ST_NEXT;
          end else begin
            match_nxt = match_cnt + MATCH_W'(1);
          end
        end else if (slip_cnt == SLIP_LAST) begin
          // Every bit position tried without a full match run: give up on this channel.
          fail_nxt  = 1'b1;
          state_nxt = ST_NEXT;
        end else begin
          // Pulse is registered, so it is high exactly while the FSM sits in SLIP.
          bitslip_nxt = ch_onehot;
          state_nxt   = ST_SLIP;
        end
      end
      ST_SLIP: begin
        slip_nxt  = slip_cnt + SLIP_W'(1);
        wait_nxt  = '0;
        state_nxt = ST_WAIT;
      end
      ST_NEXT: begin
        if (ch_idx == CH_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          ch_nxt    = ch_idx + CH_W'(1);
          slip_nxt  = '0;
          wait_nxt  = '0;
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt     = (state_nxt == ST_WAIT) || (state_nxt == ST_CHECK) ||
                   (state_nxt == ST_SLIP) || (state_nxt == ST_NEXT);
    done_nxt     = (state_nxt == ST_DONE);
    fail_out_nxt = (state_nxt == ST_DONE) && fail_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ch_idx    <= '0;
      slip_cnt  <= '0;
      wait_cnt  <= '0;
      match_cnt <= '0;
      fail_flag <= 1'b0;
      chn_lock  <= '0;
      bitslip   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch_idx    <= ch_nxt;
      slip_cnt  <= slip_nxt;
      wait_cnt  <= wait_nxt;
      match_cnt <= match_nxt;
      fail_flag <= fail_nxt;
      chn_lock  <= lock_nxt;
      bitslip   <= bitslip_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      fail_out  <= fail_out_nxt;
    end
  end

  assign bus.ov_bitslip   = bitslip;
  assign bus.ov_chn_lock  = chn_lock;
  assign bus.o_align_busy = busy;
  assign bus.o_align_done = done;
  assign bus.o_align_fail = fail_out;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Bench for deser_align_ctrl: models the ISERDES as a per-channel word that rotates
// on every bitslip pulse, and predicts lock/fail/pulse counts/timing per channel.
module tb_deser_align_ctrl;

  localparam int CN = 4;
  localparam int W  = 6;
  localparam int SW = 4;
  localparam int MN = 16;
  localparam logic [W-1:0] TW = 6'h38;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  deser_align_ctrl_if #(.CHANNEL_NUM(CN), .DESER_WIDTH(W)) bus ();

  deser_align_ctrl #(
    .CHANNEL_NUM(CN), .DESER_WIDTH(W), .TRAINING_WORD(TW),
    .SLIP_WAIT(SW), .MATCH_NUM(MN)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Deserializer model state
  logic [W-1:0]  word [CN];
  logic [CN-1:0] rot_en;

  // Reference-model predictions
  logic [CN-1:0] exp_lock;
  logic          exp_fail;
  int            exp_cycles;
  int            exp_slips [CN];

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]};
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x);
    return {x[0], x[W-1:1]};
  endfunction

  task automatic drive_data(input logic corrupt0);
    for (int c = 0; c < CN; c++)
      bus.iv_data[c*W +: W] = (corrupt0 && c == 0) ? (TW ^ 6'h01) : word[c];
  endtask

  // Per channel: find how many rotations bring the word onto the training word.
  // A glitch after glitch_len good words on channel 0 costs one extra slip.
  task automatic compute_model(input int glitch_len);
    exp_cycles = 0;
    exp_fail   = 1'b0;
    exp_lock   = '0;
    for (int c = 0; c < CN; c++) begin
      logic [W-1:0] x;
      int k;
      int extra;
      x = word[c];
      k = -1;
      extra = 0;
      for (int j = 0; j < W; j++) begin
        if (k < 0 && x == TW) k = j;
        if (rot_en[c]) x = rotl(x);
      end
      if (c == 0 && glitch_len > 0) begin
        k = 1;
        extra = glitch_len;
      end
      if (k >= 0) begin
        exp_lock[c]  = 1'b1;
        exp_slips[c] = k;
        exp_cycles  += SW + k * (SW + 2) + MN + 1 + extra;
      end else begin
        exp_fail     = 1'b1;
        exp_slips[c] = W - 1;
        exp_cycles  += W * (SW + 1) + (W - 1) + 1;
      end
    end
  endtask

  // Pulses i_start, follows the run to done and checks everything against the model.
  // inj_n >= 0 re-pulses i_start n cycles after the start edge (must be ignored).
  task automatic run_seq(input string name, input int glitch_len, input int inj_n);
    int n, busy_cnt, done_n, onehot_err, space_err;
    logic first_busy;
    int pulses [CN];
    int last [CN];
    compute_model(glitch_len);
    busy_cnt = 0; done_n = -1; onehot_err = 0; space_err = 0; first_busy = 1'b0;
    for (int c = 0; c < CN; c++) begin pulses[c] = 0; last[c] = -1; end
    drive_data(1'b0);
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    n = 0;
    while (done_n < 0 && n < exp_cycles + 60) begin
      if (n == 0) first_busy = bus.o_align_busy;
      if (bus.o_align_busy) busy_cnt++;
      if (bus.o_align_done) done_n = n;
      if (!$onehot0(bus.ov_bitslip)) onehot_err++;
      for (int c = 0; c < CN; c++) begin
        if (bus.ov_bitslip[c]) begin
          pulses[c]++;
          if (last[c] >= 0 && (n - last[c]) != SW + 2) space_err++;
          last[c] = n;
          if (rot_en[c]) word[c] = rotl(word[c]);
        end
      end
      bus.i_start = (n == inj_n);
      drive_data(glitch_len > 0 && n == SW + glitch_len);
      n++;
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    drive_data(1'b0);

    checks++;
    if (done_n < 0) begin
      errors++;
      $display("FAIL %s timeout: done never seen within %0d cycles, required at %0d", name, n, exp_cycles);
    end
    checks++;
    if (first_busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_first_cycle got %b want 1", name, first_busy);
    end
    checks++;
    if (done_n !== exp_cycles) begin
      errors++; $display("FAIL %s done_time got %0d want %0d", name, done_n, exp_cycles);
    end
    checks++;
    if (busy_cnt !== exp_cycles) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, exp_cycles);
    end
    checks++;
    if (bus.ov_chn_lock !== exp_lock) begin
      errors++; $display("FAIL %s chn_lock got %b want %b", name, bus.ov_chn_lock, exp_lock);
    end
    checks++;
    if (bus.o_align_fail !== exp_fail) begin
      errors++; $display("FAIL %s align_fail got %b want %b", name, bus.o_align_fail, exp_fail);
    end
    for (int c = 0; c < CN; c++) begin
      checks++;
      if (pulses[c] !== exp_slips[c]) begin
        errors++; $display("FAIL %s bitslip_count ch%0d got %0d want %0d", name, c, pulses[c], exp_slips[c]);
      end
    end
    checks++;
    if (onehot_err !== 0) begin
      errors++; $display("FAIL %s bitslip_onehot violations %0d want 0", name, onehot_err);
    end
    checks++;
    if (space_err !== 0) begin
      errors++; $display("FAIL %s bitslip_spacing violations %0d want 0", name, space_err);
    end
    @(negedge clk);
    checks++;
    if (bus.o_align_done !== 1'b1 || bus.o_align_busy !== 1'b0) begin
      errors++; $display("FAIL %s done_hold got done=%b busy=%b want done=1 busy=0", name, bus.o_align_done, bus.o_align_busy);
    end
  endtask

  task automatic set_all_aligned();
    for (int c = 0; c < CN; c++) word[c] = TW;
    rot_en = '1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.i_start = 1'b0;
    set_all_aligned();
    drive_data(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ov_bitslip, bus.ov_chn_lock, bus.o_align_busy, bus.o_align_done, bus.o_align_fail} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got bitslip=%b lock=%b busy=%b done=%b fail=%b want all 0",
               bus.ov_bitslip, bus.ov_chn_lock, bus.o_align_busy, bus.o_align_done, bus.o_align_fail);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_aligned();
    set_all_aligned();
    run_seq("all_aligned", 0, -1);
  endtask

  task automatic test_slip_ch2();
    set_all_aligned();
    word[2] = rotr(rotr(rotr(TW)));
    run_seq("slip_ch2", 0, -1);
  endtask

  task automatic test_stuck_ch1();
    set_all_aligned();
    word[1] = 6'h00;
    run_seq("stuck_ch1", 0, -1);
  endtask

  task automatic test_glitch_ch0();
    set_all_aligned();
    rot_en = '0;
    run_seq("glitch_ch0", 10, -1);
  endtask

  task automatic test_reset_mid();
    set_all_aligned();
    drive_data(1'b0);
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    // Channel 1 is in CHECK for cycles 25..40 after the start edge.
    for (int n = 0; n < 30; n++) @(negedge clk);
    checks++;
    if (bus.ov_chn_lock !== 4'b0001) begin
      errors++; $display("FAIL reset_mid_prelock got %b want 0001", bus.ov_chn_lock);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ov_bitslip, bus.ov_chn_lock, bus.o_align_busy, bus.o_align_done, bus.o_align_fail} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got bitslip=%b lock=%b busy=%b done=%b fail=%b want all 0",
               bus.ov_bitslip, bus.ov_chn_lock, bus.o_align_busy, bus.o_align_done, bus.o_align_fail);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.o_align_busy !== 1'b0 || bus.ov_bitslip !== '0) begin
        errors++; $display("FAIL reset_mid_idle got busy=%b bitslip=%b want 0/0", bus.o_align_busy, bus.ov_bitslip);
      end
    end
    run_seq("realign_after_reset", 0, -1);
  endtask

  task automatic test_start_while_busy();
    set_all_aligned();
    word[3] = rotr(TW);
    run_seq("start_while_busy", 0, 37);
  endtask

  task automatic test_restart_in_done();
    int n;
    set_all_aligned();
    rot_en = '0;
    word[1] = 6'h00;
    run_seq("restart_first", 0, -1);
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    checks++;
    if (bus.ov_chn_lock !== '0 || bus.o_align_done !== 1'b0 || bus.o_align_fail !== 1'b0 || bus.o_align_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got lock=%b done=%b fail=%b busy=%b want 0000/0/0/1",
               bus.ov_chn_lock, bus.o_align_done, bus.o_align_fail, bus.o_align_busy);
    end
    n = 0;
    while (!bus.o_align_done && n < exp_cycles + 60) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== exp_cycles) begin
      errors++; $display("FAIL restart_done_time got %0d want %0d", n, exp_cycles);
    end
    checks++;
    if (bus.ov_chn_lock !== 4'b1101 || bus.o_align_fail !== 1'b1) begin
      errors++; $display("FAIL restart_result got lock=%b fail=%b want 1101/1", bus.ov_chn_lock, bus.o_align_fail);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < CN; c++) begin
        if ($urandom_range(0, 4) == 0) begin
          word[c]   = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'h3F;
          rot_en[c] = 1'b1;
        end else begin
          logic [W-1:0] x;
          int r;
          x = TW;
          r = $urandom_range(0, W - 1);
          for (int j = 0; j < r; j++) x = rotr(x);
          word[c]   = x;
          rot_en[c] = 1'b1;
        end
      end
      run_seq($sformatf("random_%0d", it), 0,
              ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 40)));
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.iv_data = '0;
    reset_n     = 1'b0;
    test_reset();
    test_all_aligned();
    test_slip_ch2();
    test_stuck_ch1();
    test_glitch_ch0();
    test_reset_mid();
    test_start_while_busy();
    test_restart_in_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
